ahb_slave: RTL and testbench
============================

# ahb_slave

AHB slave with an internal byte-addressable RAM; it is the responder counterpart to `ahb_master` and serves as its bench target and as an on-chip scratch memory. It accepts pipelined address and data phases and inserts a configurable number of wait states. It issues the two-cycle ERROR response for illegal transfers and returns OKAY for everything else.

## Interface
- `DATA_WDT`, 32: data bus width in bits (32 or 64).
- `DEPTH`, 1024: RAM depth in words of `DATA_WDT`.
- `WAIT_STATES`, 0: wait cycles inserted before completing each OKAY data phase (0..15).

- `i_hclk` in 1: clock. One clock domain; all logic on rising edge.
- `i_hreset` in 1: reset, synchronous, active-high.
- `i_hsel` in 1: slave select.
- `i_haddr` in 32: byte address.
- `i_htrans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `i_hburst` in 3: burst type. Ignored, because every beat carries its own address.
- `i_hwrite` in 1: 1 = write.
- `i_hsize` in 3: transfer size, 2^hsize bytes.
- `i_hwdata` in DATA_WDT: write data, valid in the data phase.
- `i_hreadyin` in 1: bus HREADY. The address phase is sampled only when this is 1.
- `o_hrdata` out DATA_WDT: read data.
- `o_hready` out 1: data phase complete.
- `o_hresp` out 2: OKAY=00, ERROR=01. RETRY and SPLIT are never issued.

## Operation
- **Accept:** an address phase is accepted when `i_hsel & i_hreadyin & i_htrans[1]`. On acceptance, register addr, write, size and an error flag.
- **Error flag:** set if any of the following holds:
  - word index `haddr >> log2(DATA_WDT/8)` is ≥ `DEPTH`;
  - `hsize` is greater than `log2(DATA_WDT/8)`;
  - `haddr` is not aligned to `2^hsize`.
- **IDLE/BUSY or unselected:** no data phase is started. The next cycle shows `o_hready`=1 and OKAY.
- **States:**
  - `ST_IDLE`: `o_hready`=1, OKAY.
  - `ST_WAIT`: `o_hready`=0, OKAY; wait counter decrements.
  - `ST_DATA`: `o_hready`=1, OKAY. The transfer completes in this cycle.
  - `ST_ERR1`: `o_hready`=0, ERROR.
  - `ST_ERR2`: `o_hready`=1, ERROR.
- **Transitions from any completing state** (`ST_IDLE`, `ST_DATA`, `ST_ERR2`):
  - accepted transfer with error → `ST_ERR1`;
  - accepted OKAY transfer with `WAIT_STATES`=0 → `ST_DATA`;
  - accepted OKAY transfer with `WAIT_STATES`>0 → `ST_WAIT`, counter loaded with `WAIT_STATES`-1;
  - otherwise → `ST_IDLE`.
- **Other transitions:**
  - `ST_WAIT` → `ST_DATA` when the counter is 0.
  - `ST_ERR1` → `ST_ERR2` unconditionally.
- **Write:** committed at the end of the `ST_DATA` cycle using `i_hwdata`. Byte enables come from hsize and `haddr[log2(DATA_WDT/8)-1:0]`, little-endian. Unaddressed bytes are unchanged.
- **Read:** `o_hrdata` is the full RAM word at the registered word index, driven combinationally in `ST_DATA`. It is 0 in all other states. The master extracts byte lanes.
- **Errored transfers:** never touch the RAM. `o_hrdata` is 0.
- **Back-to-back write then read of the same address:** the read returns the new data, because the write commits before the read's data cycle.
- **Reset:** synchronous.
  - Reset is not a RAM-clear mechanism; RAM contents are retained.
  - On reset, the state goes to `ST_IDLE`, the wait counter to 0 and registered control to 0.
  - A pending write is dropped.

## Timing
- Reset values: `o_hready`=1, `o_hresp`=00, `o_hrdata`=0.
- Latency with `WAIT_STATES`=N: the data phase lasts N+1 cycles after the address phase. Only the last of those cycles has `o_hready`=1.
- A new address phase overlaps the completing data phase. Zero-wait bursts sustain one beat per cycle.
- ERROR always takes exactly 2 cycles, independent of `WAIT_STATES`.
  - Address phases presented during `ST_ERR1` are not sampled, since `i_hreadyin` is 0.
  - A new address phase is sampled during `ST_ERR2`.
- During `ST_WAIT` and `ST_ERR1` the master holds the address/control lines. The slave ignores them because `i_hreadyin` is 0.

## Structure
- Package `ahb_pkg`:
  - `htrans_t` (IDLE, BUSY, NONSEQ, SEQ);
  - `hresp_t` (OKAY, ERROR, RETRY, SPLIT);
  - `hburst_t`;
  - `hsize_t`;
  - the slave state enum.
- Sub-module `ahb_slave_ram`: `DEPTH`×`DATA_WDT` array with a synchronous byte-enable write port and a combinational read port. The FSM, error decode and byte-enable generation live in `ahb_slave`.

## Test plan
- **Zero-wait write/read** (`WAIT_STATES`=0): NONSEQ write 0xDEADBEEF to 0x10 → `o_hready`=1 the next cycle, OKAY. NONSEQ read of 0x10 → `o_hrdata`=0xDEADBEEF in its data cycle.
- **Wait states** (`WAIT_STATES`=3): single read → `o_hready` low for 3 cycles, high on the 4th, data valid on the 4th.
- **Byte write:** hsize=0 write 0xAB to 0x13 over a word holding 0x11223344 → readback 0xAB223344.
- **Error cases:** address 0x1000 with `DEPTH`=1024, and hsize=2 at 0x2 → ERROR with `o_hready`=0 then 1. The RAM word is unchanged. A NONSEQ presented in `ST_ERR2` is accepted.
- **Burst through master:** drive with `ahb_master`, INCR read of 20 beats → 20 OKAY beats, addresses incrementing by 4. Also a write-then-read of the same address back to back → the new data is returned.
- **Mid-operation reset:** assert `i_hreset` in `ST_WAIT` during a write → `o_hready`=1, OKAY the next cycle. The targeted word is unchanged and other RAM contents are retained.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the responder state type used by ahb_slave and its bench.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_t;

endpackage

// File: rtl/ahb_slave_ram.sv
// Word-wide scratch RAM: synchronous byte-enable write, combinational read, no reset.
module ahb_slave_ram #(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DATA_WDT/8-1:0] i_be,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WDT-1:0]   i_wdata,
    output logic [DATA_WDT-1:0]   o_rdata
);

    logic [DATA_WDT-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WDT / 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave.sv
// AHB responder in front of ahb_slave_ram: pipelined address/data phases,
// WAIT_STATES stall cycles per OKAY beat, and the two-cycle ERROR response.
module ahb_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WDT    = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic [2:0]          i_hburst,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hreadyin,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output logic [1:0]          o_hresp,
    output logic [2:0]          o_dbg_state
);

    localparam int BYTES = DATA_WDT / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);

    slv_state_t          r_state;
    logic [3:0]          r_wait_cnt;
    logic [AW-1:0]       r_word;
    logic                r_write;
    logic [BYTES-1:0]    r_be;
    logic                r_hready;
    hresp_t              r_hresp;

    logic                w_accept;
    logic [31:0]         w_word_idx;
    logic                w_err_range;
    logic                w_err_size;
    logic [7:0]          w_align_mask;
    logic                w_err_align;
    logic                w_err;
    logic [BYTES-1:0]    w_be;
    logic                w_ram_we;
    logic [DATA_WDT-1:0] w_ram_rdata;
    logic                w_unused;

    // Handshake: an address phase is taken only on a cycle where the bus HREADY
    // (i_hreadyin) is high; a data phase ends on the first cycle o_hready is high.
    assign w_accept = i_hsel & i_hreadyin & i_htrans[1];

    assign w_word_idx   = i_haddr >> OFS;
    assign w_err_range  = w_word_idx >= 32'(DEPTH);
    assign w_err_size   = i_hsize > 3'(OFS);
    assign w_align_mask = 8'((9'd1 << i_hsize) - 9'd1);
    assign w_err_align  = |(i_haddr[7:0] & w_align_mask);
    assign w_err        = w_err_range | w_err_size | w_err_align;

    // A lane is enabled when it falls in the same 2^hsize-byte chunk as the address.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < BYTES; b++) begin
            if ((b >> i_hsize) == (int'(i_haddr[OFS-1:0]) >> i_hsize)) begin
                w_be[b] = 1'b1;
            end
        end
    end

    assign w_unused = ^{i_hburst, i_htrans[0]};

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_word     <= '0;
            r_write    <= 1'b0;
            r_be       <= '0;
            r_hready   <= 1'b1;
            r_hresp    <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (w_accept) begin
                        r_word  <= w_word_idx[AW-1:0];
                        r_write <= i_hwrite & ~w_err;
                        r_be    <= w_be;
                        if (w_err) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= ST_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= HRESP_OKAY;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= 4'(WAIT_STATES - 1);
                            r_hready   <= 1'b0;
                            r_hresp    <= HRESP_OKAY;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state  <= ST_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                        r_hready   <= 1'b0;
                    end
                    r_hresp <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // A reset landing on the data cycle drops the write.
    assign w_ram_we = (r_state == ST_DATA) & r_write & ~i_hreset;

    ahb_slave_ram #(
        .DATA_WDT (DATA_WDT),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_ram (
        .i_clk   (i_hclk),
        .i_we    (w_ram_we),
        .i_be    (r_be),
        .i_addr  (r_word),
        .i_wdata (i_hwdata),
        .o_rdata (w_ram_rdata)
    );

    assign o_hrdata    = (r_state == ST_DATA) ? w_ram_rdata : '0;
    assign o_hready    = r_hready;
    assign o_hresp     = r_hresp;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_slave.sv
// Bench for ahb_slave: a zero-wait and a three-wait instance, table vectors,
// hand-written pipeline/error/reset sequences and random traffic against a byte model.
module tb_ahb_slave;
    import ahb_pkg::*;

    localparam int RAM_BYTES = 1024 * 4;
    localparam int MODEL_BYTES = 128;

    logic        clk;
    logic        rst      [2];
    logic        sel      [2];
    logic [31:0] addr     [2];
    logic [1:0]  trans    [2];
    logic [2:0]  burst    [2];
    logic        write    [2];
    logic [2:0]  size     [2];
    logic [31:0] wdata    [2];
    logic        hreadyin [2];
    logic        ovr      [2];
    logic [31:0] hrdata   [2];
    logic        hready   [2];
    logic [1:0]  hresp    [2];
    logic [2:0]  dbg      [2];

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [2][MODEL_BYTES];

    typedef struct {
        int          k;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[$];

    assign hreadyin[0] = hready[0] & ~ovr[0];
    assign hreadyin[1] = hready[1] & ~ovr[1];

    ahb_slave #(.DATA_WDT(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .i_hclk(clk), .i_hreset(rst[0]), .i_hsel(sel[0]), .i_haddr(addr[0]),
        .i_htrans(trans[0]), .i_hburst(burst[0]), .i_hwrite(write[0]), .i_hsize(size[0]),
        .i_hwdata(wdata[0]), .i_hreadyin(hreadyin[0]), .o_hrdata(hrdata[0]),
        .o_hready(hready[0]), .o_hresp(hresp[0]), .o_dbg_state(dbg[0])
    );

    ahb_slave #(.DATA_WDT(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .i_hclk(clk), .i_hreset(rst[1]), .i_hsel(sel[1]), .i_haddr(addr[1]),
        .i_htrans(trans[1]), .i_hburst(burst[1]), .i_hwrite(write[1]), .i_hsize(size[1]),
        .i_hwdata(wdata[1]), .i_hreadyin(hreadyin[1]), .o_hrdata(hrdata[1]),
        .o_hready(hready[1]), .o_hresp(hresp[1]), .o_dbg_state(dbg[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit pred_err(input logic [31:0] a, input logic [2:0] sz);
        return (a >= 32'(RAM_BYTES)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
    endfunction

    function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a & ~32'h3);
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = ref_mem[k][base + i];
        return w;
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
        int idx;
        if (a < 32'(MODEL_BYTES)) begin
            for (int i = 0; i < (1 << sz); i++) begin
                idx = int'(a) + i;
                ref_mem[k][idx] = wd[(idx % 4)*8 +: 8];
            end
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle(input int k);
        sel[k]   = 1'b0;
        trans[k] = HTRANS_IDLE;
        write[k] = 1'b0;
    endtask

    // Called just after a rising edge with the slave ready; returns just after
    // the edge that completes the data phase.
    task automatic do_xfer(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd,
                           input string tag);
        int  lows;
        bit  done;
        bit  bad_low;
        sel[k] = 1'b1; trans[k] = HTRANS_NONSEQ; addr[k] = a; write[k] = wr; size[k] = sz;
        @(posedge clk); #1;
        bus_idle(k);
        wdata[k] = wd;
        lows = 0; done = 0; bad_low = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (hready[k]) begin
                done = 1;
            end else begin
                lows++;
                if (hresp[k] != (exp_err ? 2'b01 : 2'b00) || hrdata[k] != 32'h0) bad_low = 1;
                @(posedge clk); #1;
            end
        end
        check({tag, " stall cycles"}, done ? 32'(lows) : 32'hFFFF_FFFF,
              exp_err ? 32'd1 : 32'(wait_of(k)));
        check({tag, " stall resp/rdata"}, 32'(bad_low), 32'd0);
        check({tag, " resp"}, 32'(hresp[k]), exp_err ? 32'd1 : 32'd0);
        if (!wr || exp_err) check({tag, " rdata"}, hrdata[k], exp_err ? 32'h0 : exp_rd);
        @(posedge clk); #1;
    endtask

    task automatic add_vec(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit e, input logic [31:0] rd);
        vec_t v;
        v.k = k; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd; v.exp_err = e; v.exp_rd = rd;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; ovr[k] = 1'b0; burst[k] = 3'd0; size[k] = 3'd2;
            addr[k] = 32'h0; wdata[k] = 32'h0;
            bus_idle(k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset hready", 32'(hready[k]), 32'd1);
            check("reset hresp", 32'(hresp[k]), 32'd0);
            check("reset hrdata", hrdata[k], 32'h0);
        end
        @(posedge clk); #1;

        // Give every modelled word a known value.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < MODEL_BYTES / 4; w++) begin
                logic [31:0] d;
                d = $urandom;
                do_xfer(k, 1'b1, 3'd2, 32'(w * 4), d, 1'b0, 32'h0, "preload");
                model_write(k, 32'(w * 4), 3'd2, d);
            end
        end

        // Table vectors: expected values worked out by hand.
        add_vec(0, 1, 3'd2, 32'h10,   32'hDEADBEEF, 0, 32'h0);
        add_vec(0, 0, 3'd2, 32'h10,   32'h0,        0, 32'hDEADBEEF);
        add_vec(0, 1, 3'd2, 32'h10,   32'h11223344, 0, 32'h0);
        add_vec(0, 1, 3'd0, 32'h13,   32'hAB000000, 0, 32'h0);
        add_vec(0, 0, 3'd2, 32'h10,   32'h0,        0, 32'hAB223344);
        add_vec(0, 1, 3'd1, 32'h10,   32'h00005566, 0, 32'h0);
        add_vec(0, 0, 3'd2, 32'h10,   32'h0,        0, 32'hAB225566);
        add_vec(0, 1, 3'd2, 32'h1000, 32'hFFFFFFFF, 1, 32'h0);
        add_vec(0, 1, 3'd2, 32'h2,    32'hFFFFFFFF, 1, 32'h0);
        add_vec(0, 0, 3'd2, 32'h2,    32'h0,        1, 32'h0);
        add_vec(0, 0, 3'd3, 32'h8,    32'h0,        1, 32'h0);
        add_vec(0, 1, 3'd1, 32'h11,   32'hFFFFFFFF, 1, 32'h0);
        add_vec(0, 0, 3'd2, 32'h10,   32'h0,        0, 32'hAB225566);
        add_vec(1, 1, 3'd2, 32'h40,   32'hCAFEF00D, 0, 32'h0);
        add_vec(1, 0, 3'd2, 32'h40,   32'h0,        0, 32'hCAFEF00D);
        add_vec(1, 1, 3'd0, 32'h41,   32'h00005A00, 0, 32'h0);
        add_vec(1, 0, 3'd2, 32'h40,   32'h0,        0, 32'hCAFE5A0D);
        add_vec(1, 1, 3'd2, 32'hFFC,  32'h01020304, 0, 32'h0);
        add_vec(1, 0, 3'd2, 32'hFFC,  32'h0,        0, 32'h01020304);
        add_vec(1, 0, 3'd2, 32'h1004, 32'h0,        1, 32'h0);
        add_vec(1, 1, 3'd1, 32'h3,    32'h0,        1, 32'h0);
        foreach (vecs[i]) begin
            do_xfer(vecs[i].k, vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd,
                    vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));
            if (vecs[i].wr && !vecs[i].exp_err) model_write(vecs[i].k, vecs[i].a, vecs[i].sz, vecs[i].wd);
        end

        // Unselected, BUSY and stalled-bus address phases start no data phase.
        sel[0] = 1'b0; trans[0] = HTRANS_NONSEQ; addr[0] = 32'h10; write[0] = 1'b0;
        @(posedge clk); #1; bus_idle(0);
        @(negedge clk);
        check("unsel hready", 32'(hready[0]), 32'd1);
        check("unsel rdata", hrdata[0], 32'h0);
        @(posedge clk); #1;
        sel[1] = 1'b1; trans[1] = HTRANS_BUSY; addr[1] = 32'h40;
        @(posedge clk); #1; bus_idle(1);
        @(negedge clk);
        check("busy hready", 32'(hready[1]), 32'd1);
        @(posedge clk); #1;
        sel[1] = 1'b1; trans[1] = HTRANS_NONSEQ; addr[1] = 32'h40; ovr[1] = 1'b1;
        @(posedge clk); #1; bus_idle(1); ovr[1] = 1'b0;
        @(negedge clk);
        check("readyin low hready", 32'(hready[1]), 32'd1);
        @(posedge clk); #1;

        // Zero-wait pipelined INCR read of 20 beats.
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) begin
                sel[0] = 1'b1; trans[0] = (c == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                addr[0] = 32'(c * 4); write[0] = 1'b0; size[0] = 3'd2;
            end else begin
                bus_idle(0);
            end
            if (c >= 1) begin
                @(negedge clk);
                check("burst hready", 32'(hready[0]), 32'd1);
                check("burst hresp", 32'(hresp[0]), 32'd0);
                check("burst rdata", hrdata[0], model_word(0, 32'((c - 1) * 4)));
            end
            @(posedge clk); #1;
        end

        // Back-to-back write then read of one address.
        sel[0] = 1'b1; trans[0] = HTRANS_NONSEQ; addr[0] = 32'h24; write[0] = 1'b1; size[0] = 3'd2;
        @(posedge clk); #1;
        wdata[0] = 32'h0BADF00D; write[0] = 1'b0;
        @(negedge clk);
        check("b2b write hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        model_write(0, 32'h24, 3'd2, 32'h0BADF00D);
        bus_idle(0);
        @(negedge clk);
        check("b2b read rdata", hrdata[0], 32'h0BADF00D);
        @(posedge clk); #1;

        // Error, then a NONSEQ held through ERR1 and sampled in ERR2.
        sel[0] = 1'b1; trans[0] = HTRANS_NONSEQ; addr[0] = 32'h1000; write[0] = 1'b1; size[0] = 3'd2;
        @(posedge clk); #1;
        addr[0] = 32'h10; write[0] = 1'b0;
        @(negedge clk);
        check("err1 hready", 32'(hready[0]), 32'd0);
        check("err1 hresp", 32'(hresp[0]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("err2 hready", 32'(hready[0]), 32'd1);
        check("err2 hresp", 32'(hresp[0]), 32'd1);
        @(posedge clk); #1;
        bus_idle(0);
        @(negedge clk);
        check("after err hready", 32'(hready[0]), 32'd1);
        check("after err hresp", 32'(hresp[0]), 32'd0);
        check("after err rdata", hrdata[0], model_word(0, 32'h10));
        @(posedge clk); #1;

        // Reset during the wait states of a write.
        sel[1] = 1'b1; trans[1] = HTRANS_NONSEQ; addr[1] = 32'h40; write[1] = 1'b1; size[1] = 3'd2;
        @(posedge clk); #1;
        bus_idle(1); wdata[1] = 32'h12345678; rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("midrst hready", 32'(hready[1]), 32'd1);
        check("midrst hresp", 32'(hresp[1]), 32'd0);
        check("midrst state", 32'(dbg[1]), 32'(ST_IDLE));
        @(posedge clk); #1;
        do_xfer(1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, model_word(1, 32'h40), "midrst target");
        do_xfer(1, 1'b0, 3'd2, 32'h44, 32'h0, 1'b0, model_word(1, 32'h44), "midrst other");

        // Random traffic against the byte model.
        for (int n = 0; n < 80; n++) begin
            int          k;
            bit          wr;
            bit          e;
            logic [2:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            k  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, MODEL_BYTES - 1));
            if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            e  = pred_err(a, sz);
            do_xfer(k, wr, sz, a, wd, e, (e || wr) ? 32'h0 : model_word(k, a), "rand");
            if (wr && !e) model_write(k, a, sz, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
